// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-result countdowns beside ID.
// Stalls the ID instruction on RAW against any pending result, or on WAW
// when an older result would land after the new one. Also keeps a
// saturating count of stall cycles for debug.
module hazard_scoreboard #(
  parameter int NUM_REGS = 4,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LAT  = 3,
  parameter int CNT_W    = 16,
  localparam int REG_AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int LAT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC-1:0]        id_src_en,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic                      id_dst_en,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic [LAT_W-1:0]          id_lat,
  input  logic                      flush,
  input  logic                      clr_stats,
  output logic                      stall,
  output logic [NUM_REGS-1:0]       busy_mask,
  output logic [CNT_W-1:0]          stall_count
);

  // Handshake: id_valid is the ID-side valid and ~stall acts as its ready;
  // an instruction issues on a rising edge where id_valid & ~flush & ~stall.
  // flush drops the ID instruction without issuing it and without stalling.

  logic [LAT_W-1:0] count_q [NUM_REGS];
  logic [LAT_W-1:0] count_d [NUM_REGS];
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;
  logic [LAT_W-1:0] lat_eff;
  logic             raw_hit;
  logic             waw_hit;
  logic             issue;

  // Clamp the requested latency so an oversized value never wraps.
  always_comb begin
    lat_eff = id_lat;
    if (id_lat > LAT_W'(MAX_LAT)) lat_eff = LAT_W'(MAX_LAT);
  end

  // Hazard terms from registered counts only; out-of-range numbers never match.
  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (id_src_en[i] && (id_src_addr[i*REG_AW +: REG_AW] == REG_AW'(r)) &&
            (count_q[r] != '0))
          raw_hit = 1'b1;
      end
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (id_dst_en && (id_dst_addr == REG_AW'(r)) && (count_q[r] > lat_eff))
        waw_hit = 1'b1;
    end
    stall = id_valid & ~flush & (raw_hit | waw_hit);
    issue = id_valid & ~flush & ~stall;
  end

  // Next countdowns: an issuing load with nonzero latency overrides the decrement.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d[r] = count_q[r];
      if (issue && id_dst_en && (id_dst_addr == REG_AW'(r)) && (lat_eff != '0))
        count_d[r] = lat_eff;
      else if (count_q[r] != '0)
        count_d[r] = count_q[r] - LAT_W'(1);
    end
  end

  // Stall statistics: clear wins, otherwise count stall cycles and saturate.
  always_comb begin
    stall_count_d = stall_count_q;
    if (clr_stats)
      stall_count_d = '0;
    else if (stall && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) count_q[r] <= '0;
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) count_q[r] <= count_d[r];
      stall_count_q <= stall_count_d;
    end
  end

  // Debug view of which registers still have a result in flight.
  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) busy_mask[r] = (count_q[r] != '0);
  end

  assign stall_count = stall_count_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard detection unit for the pipelined processor. It replaces the fixed single-cycle load-use check with a per-register scoreboard of pending-result countdowns, which covers instructions whose results become forwardable 0..MAX_LAT cycles after leaving ID. It sits beside the ID stage. It takes the ID instruction's source and destination fields and drives the PC/IF-ID freeze and the ID/EX bubble. It also keeps a saturating stall-cycle counter for debug.

## Interface
- NUM_REGS, 4: architectural register count; REG_AW = $clog2(NUM_REGS).
- NUM_SRC, 2: source operands checked per instruction.
- MAX_LAT, 3: largest tracked result latency; LAT_W = $clog2(MAX_LAT+1).
- CNT_W, 16: stall counter width.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_src_en  input  NUM_SRC  per-source read enable.
- id_src_addr  input  NUM_SRC*REG_AW  packed source register numbers; source i is at bits [i*REG_AW +: REG_AW].
- id_dst_en  input  1  instruction writes a register.
- id_dst_addr  input  REG_AW  destination register.
- id_lat  input  LAT_W  number of cycles after issue before the result is forwardable. 0 means an ALU result with full forwarding. 1 means LDD/POP-class.
- flush  input  1  the ID instruction is being squashed this cycle (branch or interrupt).
- clr_stats  input  1  synchronous clear of stall_count.
- stall  output  1  freeze PC and IF/ID, and insert a bubble into ID/EX.
- busy_mask  output  NUM_REGS  bit r = count[r] != 0.
- stall_count  output  CNT_W  saturating number of cycles with stall=1.

## Operation
- State: count[r], LAT_W bits, one per register. Also stall_count.
- RAW term: any i with id_src_en[i] and count[src_i] != 0.
- WAW term: id_dst_en and count[id_dst_addr] > lat_eff.
- lat_eff = min(id_lat, MAX_LAT). Values above MAX_LAT are clamped and never wrap.
- stall = id_valid & ~flush & (RAW | WAW). This is purely combinational from registered counts and ID inputs.
- issue = id_valid & ~flush & ~stall.
- Per register, each rising edge:
  - If issue & id_dst_en & id_dst_addr==r & lat_eff!=0: count[r] <= lat_eff. The issue load overrides the decrement.
  - Else if count[r]!=0: count[r] <= count[r]-1.
  - Else count[r] holds 0.
- Issue with lat_eff=0 leaves count[dst] decrementing normally. No entry is created.
- A source that reads the same register it writes is checked against the old count (RAW first).
- Duplicate sources (src0==src1) behave the same as a single source.
- A disabled source (id_src_en[i]=0) never stalls, whatever its address.
- flush: the ID instruction never issues and never stalls. Existing counts still decrement. Older in-flight results are unaffected.
- stall_count: +1 on each edge where stall=1. It saturates at 2^CNT_W-1. clr_stats has priority over increment and loads 0.
- Out-of-range register numbers (when NUM_REGS is not a power of 2) never match and never stall.

## Timing
- Reset (rst=0, asynchronous): all count=0, stall_count=0. Therefore stall=0 and busy_mask=0 while in reset and on the first cycle after release.
- An issue at edge N with latency L sets count=L. A dependent instruction in ID at cycles N+1..N+L sees stall=1. At N+L+1 it issues. This gives exactly L bubbles, so LDD followed by a dependent ADD gives 1 bubble.
- Independent instructions see no stall and issue every cycle.
- busy_mask is registered-derived. It changes only on clock edges or on reset.
- Reset asserted mid-countdown clears every count immediately. No stall occurs after release.
- stall never depends on itself. There are no combinational loops through issue.

## Test plan
- Load-use with id_lat=1, dst=R1, then ADD with src R1 in the next cycle -> stall=1 for exactly 1 cycle. Issue follows. stall_count=1. busy_mask=4'b0010 for one cycle.
- id_lat=3 on R2, followed by a reader of R2 -> 3 consecutive stall cycles. The reader issues on the 4th cycle. busy_mask bit 2 is high for 3 cycles.
- id_lat=0 producer, then a dependent consumer -> no stall, busy_mask stays 0.
- WAW: pending count[R3]=3, then an ID writer to R3 with lat 1 -> stall until count[R3] <= 1, then issue. The new count is 1.
- flush asserted while a dependent instruction is in ID -> stall=0 and no entry is created. Older counts continue down to 0.
- rst pulled low with count[R0]=2 -> busy_mask=0 and stall=0 at once. The counter saturation check preloads stall_count=2^CNT_W-1, holds stall high, and confirms it stays; clr_stats then gives 0.
